// File: rtl/input_cond_pkg.sv
// Shared constants and sizing helpers for the DE2-115 KEY/SW input conditioner.
package input_cond_pkg;

    localparam int TICK_CYCLES_100M = 100000;
    localparam int STABLE_TICKS_DEF = 10;
    localparam int SYNC_STAGES_DEF  = 2;

    // Width of a counter that must hold the values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser chain, tick-qualified stability counter and stable
// output register, with registered rise/fall pulses aligned to the output update.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic q_o,
    output logic accept_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW     = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   q_q, q_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Any cycle where the synchronised level matches the output discards progress.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        accept = 1'b0;
        if (s == q_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == C_LAST) begin
                accept = 1'b1;
                q_d    = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= RESET_LEVEL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q_o      = q_q;
    assign accept_o = accept;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces DE2-115 KEY/SW pins for the button and switch PIOs, with press/change pulses.
// Build option INPUT_COND_AUTOREPEAT_EN adds per-key hold counters for auto-repeat presses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_KEY        = 4,
    parameter int N_SW         = 18,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int TICK_CYCLES  = TICK_CYCLES_100M,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_KEY-1:0] key_raw_i,
    input  logic [N_SW-1:0]  sw_raw_i,
    output logic [N_KEY-1:0] key_o,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_KEY-1:0] key_press_o,
    output logic [N_SW-1:0]  sw_change_o,
    output logic             tick_o
);

    if (SYNC_STAGES < 2 || STABLE_TICKS < 2 || TICK_CYCLES < 2) begin : g_bad_cfg
        $error("input_conditioner: SYNC_STAGES, STABLE_TICKS and TICK_CYCLES must be >= 2");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
        $error("input_conditioner: REPEAT_RATE must be in 1..REPEAT_DELAY");
    end

    localparam int            PW     = cnt_width(TICK_CYCLES);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [N_KEY-1:0] key_acc, key_rise, key_fall;
    logic [N_SW-1:0]  sw_acc, sw_rise, sw_fall;
    logic             unused_bits;

    assign tick = (presc_q == P_LAST);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = tick;

    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (1'b1)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (key_raw_i[i]),
            .tick_i   (tick),
            .q_o      (key_o[i]),
            .accept_o (key_acc[i]),
            .rise_o   (key_rise[i]),
            .fall_o   (key_fall[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (1'b0)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (sw_raw_i[i]),
            .tick_i   (tick),
            .q_o      (sw_o[i]),
            .accept_o (sw_acc[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i])
        );
    end

    assign sw_change_o = sw_rise | sw_fall;

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int            HW       = cnt_width(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] H_FIRE   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] H_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [N_KEY-1:0][HW-1:0] hold_q, hold_d;
    logic [N_KEY-1:0]         rep_q, rep_d;

    // Reloading to DELAY-RATE after each repeat makes later repeats REPEAT_RATE ticks apart.
    // A release accepted on this tick clears the counter without firing.
    always_comb begin
        hold_d = hold_q;
        rep_d  = '0;
        for (int i = 0; i < N_KEY; i++) begin
            if (key_o[i] || key_acc[i]) begin
                hold_d[i] = '0;
            end else if (tick) begin
                if (hold_q[i] == H_FIRE) begin
                    rep_d[i]  = 1'b1;
                    hold_d[i] = H_RELOAD;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign key_press_o = key_fall | rep_q;
`else
    assign key_press_o = key_fall;
`endif

    assign unused_bits = ^{key_acc, key_rise, sw_acc};

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised scoreboard bench for input_conditioner with a tick-level reference model.
module tb_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int SS = 2;
    localparam int TC = 10;
    localparam int ST = 4;
    localparam int RD = 5;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_raw = '1;
    logic [NS-1:0] sw_raw = '0;
    logic [NK-1:0] key_o, key_press_o;
    logic [NS-1:0] sw_o, sw_change_o;
    logic          tick_o;

    always #5 clk = ~clk;

    input_conditioner #(
        .N_KEY(NK), .N_SW(NS), .SYNC_STAGES(SS), .TICK_CYCLES(TC),
        .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw_i   (key_raw),
        .sw_raw_i    (sw_raw),
        .key_o       (key_o),
        .sw_o        (sw_o),
        .key_press_o (key_press_o),
        .sw_change_o (sw_change_o),
        .tick_o      (tick_o)
    );

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NS-1:0] change;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model state: k counts clock edges since reset release.
    int            k = 0;
    logic [NK-1:0] m_key = '1;
    logic [NS-1:0] m_sw = '0;
    int            m_kc[NK];
    int            m_sc[NS];
    int            m_hold[NK];
    logic [NK-1:0] kpipe[$];
    logic [NS-1:0] spipe[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
    endtask

    task automatic model_reset();
        k = 0;
        m_key = '1;
        m_sw = '0;
        for (int i = 0; i < NK; i++) begin m_kc[i] = 0; m_hold[i] = 0; end
        for (int i = 0; i < NS; i++) m_sc[i] = 0;
        kpipe.delete();
        spipe.delete();
        for (int i = 0; i < SS; i++) begin kpipe.push_back('1); spipe.push_back('0); end
    endtask

    task automatic model_step();
        logic [NK-1:0] ks, press;
        logic [NS-1:0] ss, change;
        bit            tick;
        ev_t           ev;
        k++;
        tick = (k % TC == 0);
        ks = kpipe.pop_front(); kpipe.push_back(key_raw);
        ss = spipe.pop_front(); spipe.push_back(sw_raw);
        press = '0;
        change = '0;
        for (int i = 0; i < NK; i++) begin
            bit acc;
            acc = 0;
            if (ks[i] == m_key[i]) m_kc[i] = 0;
            else if (tick) begin
                m_kc[i]++;
                if (m_kc[i] == ST) begin acc = 1; m_kc[i] = 0; end
            end
`ifdef INPUT_COND_AUTOREPEAT_EN
            if (m_key[i] == 1'b0 && !acc && tick) begin
                m_hold[i]++;
                if (m_hold[i] >= RD && (m_hold[i] - RD) % RR == 0) press[i] = 1'b1;
            end
            if (m_key[i] == 1'b1 || acc) m_hold[i] = 0;
`endif
            if (acc) begin
                if (m_key[i] == 1'b1) press[i] = 1'b1;
                m_key[i] = ks[i];
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (ss[i] == m_sw[i]) m_sc[i] = 0;
            else if (tick) begin
                m_sc[i]++;
                if (m_sc[i] == ST) begin
                    m_sc[i] = 0;
                    m_sw[i] = ss[i];
                    change[i] = 1'b1;
                end
            end
        end
        if (press != '0 || change != '0) begin
            ev.cyc = k;
            ev.press = press;
            ev.change = change;
            exp_q.push_back(ev);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Monitor: pops an expected event whenever the DUT shows a pulse.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            check("key_o_reset", key_o, {NK{1'b1}});
            check("sw_o_reset", sw_o, '0);
            check("pulses_reset", {key_press_o, sw_change_o, tick_o}, '0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < k) begin
                n_checks++;
                $display("FAIL missed_event: no pulse seen, expected press=%0h change=%0h at cycle %0d",
                         exp_q[0].press, exp_q[0].change, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (key_press_o != '0 || sw_change_o != '0) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != k) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got press=%0h change=%0h at cycle %0d, none expected",
                             key_press_o, sw_change_o, k);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("key_press", key_press_o, ev.press);
                    check("sw_change", sw_change_o, ev.change);
                end
            end
            check("key_o", key_o, m_key);
            check("sw_o", sw_o, m_sw);
            check("tick_o", tick_o, ((k + 1) % TC == 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_key_low(input int bit_idx, output int lat, input int start);
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (key_o[bit_idx] == 1'b0) begin lat = k - start; break; end
        end
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e0, guard;
        step(20);
        reset_n = 1'b1;
        step(40);

        // Clean press on key 0 with latency bounds, then release.
        key_raw[0] = 1'b0;
        e0 = k;
        wait_key_low(0, lat, e0);
        n_checks++;
        if (lat >= (ST - 1) * TC + SS + 1 && lat <= ST * TC + SS + 1) n_pass++;
        else $display("FAIL press_latency: got %0d cycles, required %0d..%0d",
                      lat, (ST - 1) * TC + SS + 1, ST * TC + SS + 1);
        step(30);
        key_raw[0] = 1'b1;
        step(60);

        // Key 1 bouncing every 15 cycles, then held.
        for (int t = 0; t < 200 / 15; t++) begin
            key_raw[1] = ~key_raw[1];
            step(15);
        end
        key_raw[1] = 1'b0;
        step(70);
        key_raw[1] = 1'b1;
        step(60);

        // Two switches change together.
        sw_raw = 18'h2_0001;
        step(60);
        sw_raw = '0;
        step(60);

        // Reset mid-count on key 2, released with the key still pressed.
        key_raw[2] = 1'b0;
        guard = 0;
        while (m_kc[2] != 2 && guard < 200) begin step(1); guard++; end
        n_checks++;
        if (guard < 200) n_pass++;
        else $display("FAIL midcount_reach: count never reached 2 within 200 cycles");
        reset_n = 1'b0;
        step(5);
        reset_n = 1'b1;
        wait_key_low(2, lat, 0);
        check("midcount_restart", lat, ST * TC);
        step(30);
        key_raw[2] = 1'b1;
        step(60);

        // Long hold on key 3 (auto-repeat when enabled).
        key_raw[3] = 1'b0;
        step((ST + 1) * TC + 20 * TC);
        key_raw[3] = 1'b1;
        step(80);

        // Random levels with random hold lengths, including short bounces.
        for (int r = 0; r < 40; r++) begin
            key_raw = NK'($urandom);
            sw_raw  = NS'($urandom);
            step($urandom_range(3, 70));
        end
        key_raw = '1;
        sw_raw = '0;
        step(80);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
